// File: rtl/rp_8bit_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rp_8bit_trace_pkg
// Brief    : Trace record class encoding and opcode decode helpers for the
//            rp_8bit instruction trace capture block.
// Revision : 1.0 - initial release
// ============================================================================
package rp_8bit_trace_pkg;

    typedef enum logic [2:0] {
        OTHER = 3'd0,
        BRCH  = 3'd1,
        JMP   = 3'd2,
        CALL  = 3'd3,
        LDS   = 3'd4,
        STS   = 3'd5,
        RET   = 3'd6,
        UNDEF = 3'd7
    } trace_cls_t;

    // Common record payload; the top wraps it with its parametrised pc/ts fields.
    typedef struct packed {
        logic       lost;
        logic       len;
        trace_cls_t cls;
        logic [31:0] op;
    } trace_body_t;

    function automatic trace_cls_t classify(input logic [15:0] op);
        trace_cls_t cls;
        cls = OTHER;
        if (op == 16'hFFFF)
            cls = UNDEF;
        else if (op == 16'h9508 || op == 16'h9518)
            cls = RET;
        else if (op[15:9] == 7'b1001010 && op[3:2] == 2'b11)
            cls = op[1] ? CALL : JMP;
        else if (op[15:10] == 6'b100100 && op[3:0] == 4'b0000)
            cls = op[9] ? STS : LDS;
        else if (op[15:11] == 5'b11110 || op[15:13] == 3'b110)
            cls = BRCH;
        return cls;
    endfunction

    // Exactly the classes that carry a second (address) word.
    function automatic logic is_two_word(input logic [15:0] op);
        trace_cls_t cls;
        cls = classify(op);
        return (cls == JMP) || (cls == CALL) || (cls == LDS) || (cls == STS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rp_8bit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rp_8bit_trace_fifo
// Brief    : Generic synchronous FIFO with registered storage, fill level and
//            full/empty flags. Push while full is accepted only with a pop.
// Revision : 1.0 - initial release
// ============================================================================
module rp_8bit_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [DW-1:0]          i_din,
    input  logic                   i_pop,
    output logic [DW-1:0]          o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_lvl
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_lvl;
    logic            w_pop_fire;
    logic            w_push_fire;

    assign o_empty     = (r_lvl == '0);
    assign o_full      = (r_lvl == c_FULL);
    assign w_pop_fire  = i_pop & ~o_empty;
    // When full, the pop frees the head slot in the same edge the push reuses it.
    assign w_push_fire = i_push & (~o_full | w_pop_fire);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_lvl    <= '0;
        end else begin
            if (w_push_fire)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_fire)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_fire && !w_pop_fire)
                r_lvl <= r_lvl + 1'b1;
            else if (w_pop_fire && !w_push_fire)
                r_lvl <= r_lvl - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_fire)
            r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout = r_mem[r_rd_ptr];
    assign o_lvl  = r_lvl;

endmodule
`default_nettype wire

// File: rtl/rp_8bit_trace_cap.sv
`default_nettype none
// ============================================================================
// Module   : rp_8bit_trace_cap
// Brief    : Captures fetched rp_8bit words, joins two-word instructions into
//            classified trace records and queues them behind a valid/ready
//            stream with overflow accounting. Define RP_8BIT_TRACE_TS_EN to
//            add a cycle timestamp to every record (trc_ts port).
// Revision : 1.0 - initial release
// ============================================================================
module rp_8bit_trace_cap
    import rp_8bit_trace_pkg::*;
#(
    parameter int PAW   = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
`ifdef RP_8BIT_TRACE_TS_EN
    ,
    parameter int TSW   = 32
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   fch_vld,
    input  logic [PAW-1:0]         fch_pc,
    input  logic [15:0]            fch_op,
    input  logic                   flush,
    output logic                   trc_vld,
    input  logic                   trc_rdy,
    output logic [PAW-1:0]         trc_pc,
    output logic [31:0]            trc_op,
    output logic                   trc_len,
    output logic [2:0]             trc_cls,
    output logic                   trc_lost,
`ifdef RP_8BIT_TRACE_TS_EN
    output logic [TSW-1:0]         trc_ts,
`endif
    output logic                   ovf,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [$clog2(DEPTH):0] lvl
);

    typedef struct packed {
`ifdef RP_8BIT_TRACE_TS_EN
        logic [TSW-1:0] ts;
`endif
        logic [PAW-1:0] pc;
        trace_body_t    body;
    } trace_rec_t;

    localparam int         c_RW       = $bits(trace_rec_t);
    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_SECOND = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_take;
    logic             w_push;
    logic             w_latch;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_accept;
    trace_rec_t       w_rec;
    trace_rec_t       w_head;
    logic [c_RW-1:0]  w_head_bits;
    logic [PAW-1:0]   r_pc;
    logic [15:0]      r_w0;
    logic             r_lost_pend;
    logic             r_ovf;
    logic [CNT_W-1:0] r_drop_cnt;
`ifdef RP_8BIT_TRACE_TS_EN
    logic [TSW-1:0]   r_ts;
    logic [TSW-1:0]   r_ts_lat;
`endif

    assign w_take = en & fch_vld & ~flush;

    always_comb begin
        w_state_nxt       = r_state;
        w_push            = 1'b0;
        w_latch           = 1'b0;
        w_rec             = '0;
        w_rec.pc          = fch_pc;
        w_rec.body.op     = {16'h0000, fch_op};
        w_rec.body.len    = 1'b0;
        w_rec.body.cls    = classify(fch_op);
        w_rec.body.lost   = r_lost_pend;
`ifdef RP_8BIT_TRACE_TS_EN
        w_rec.ts          = r_ts;
`endif
        case (r_state)
            c_S_IDLE: begin
                if (w_take) begin
                    if (is_two_word(fch_op)) begin
                        w_latch     = 1'b1;
                        w_state_nxt = c_S_SECOND;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            c_S_SECOND: begin
                if (!en || flush) begin
                    w_state_nxt = c_S_IDLE;
                end else if (fch_vld) begin
                    w_push          = 1'b1;
                    w_rec.pc        = r_pc;
                    w_rec.body.op   = {fch_op, r_w0};
                    w_rec.body.len  = 1'b1;
                    w_rec.body.cls  = classify(r_w0);
`ifdef RP_8BIT_TRACE_TS_EN
                    w_rec.ts        = r_ts_lat;
`endif
                    w_state_nxt     = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // A push is lost only when the FIFO is full and nothing leaves this cycle.
    assign w_drop   = w_push & w_full & ~(trc_rdy & ~w_empty);
    assign w_accept = w_push & ~w_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_lost_pend <= 1'b0;
            r_ovf       <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_drop) begin
                r_lost_pend <= 1'b1;
                r_ovf       <= 1'b1;
                if (~&r_drop_cnt)
                    r_drop_cnt <= r_drop_cnt + 1'b1;
            end else if (w_accept) begin
                r_lost_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_pc <= fch_pc;
            r_w0 <= fch_op;
        end
    end

`ifdef RP_8BIT_TRACE_TS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ts <= '0;
        else
            r_ts <= r_ts + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_latch)
            r_ts_lat <= r_ts;
    end

    assign trc_ts = w_head.ts;
`endif

    rp_8bit_trace_fifo #(
        .DEPTH (DEPTH),
        .DW    (c_RW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_rec),
        .i_pop   (trc_rdy),
        .o_dout  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_lvl   (lvl)
    );

    assign w_head   = w_head_bits;
    assign trc_vld  = ~w_empty;
    assign trc_pc   = w_head.pc;
    assign trc_op   = w_head.body.op;
    assign trc_len  = w_head.body.len;
    assign trc_cls  = w_head.body.cls;
    assign trc_lost = w_head.body.lost;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rp_8bit_trace_cap.sv
`default_nettype none
// ============================================================================
// Module   : tb_rp_8bit_trace_cap
// Brief    : Directed self-checking bench for rp_8bit_trace_cap; also checks
//            trc_ts when RP_8BIT_TRACE_TS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rp_8bit_trace_cap;

    localparam int c_DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        fch_vld;
    logic [15:0] fch_pc;
    logic [15:0] fch_op;
    logic        flush;
    logic        trc_vld;
    logic        trc_rdy;
    logic [15:0] trc_pc;
    logic [31:0] trc_op;
    logic        trc_len;
    logic [2:0]  trc_cls;
    logic        trc_lost;
`ifdef RP_8BIT_TRACE_TS_EN
    logic [31:0] trc_ts;
`endif
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic [4:0]  lvl;

    int r_checks   = 0;
    int r_failures = 0;

    rp_8bit_trace_cap dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .fch_vld  (fch_vld),
        .fch_pc   (fch_pc),
        .fch_op   (fch_op),
        .flush    (flush),
        .trc_vld  (trc_vld),
        .trc_rdy  (trc_rdy),
        .trc_pc   (trc_pc),
        .trc_op   (trc_op),
        .trc_len  (trc_len),
        .trc_cls  (trc_cls),
        .trc_lost (trc_lost),
`ifdef RP_8BIT_TRACE_TS_EN
        .trc_ts   (trc_ts),
`endif
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .lvl      (lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] op);
        fch_vld = 1'b1;
        fch_pc  = pc;
        fch_op  = op;
        tick();
        fch_vld = 1'b0;
    endtask

    task automatic pop();
        trc_rdy = 1'b1;
        tick();
        trc_rdy = 1'b0;
    endtask

    // Classification vectors: word0, word1, expected class, expected length
    logic [15:0] t_w0  [10] = '{16'hF011, 16'hC123, 16'hD7FF, 16'h9518, 16'hFFFF,
                                16'hF811, 16'h9001, 16'h9000, 16'h9200, 16'h940C};
    logic [15:0] t_w1  [10] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                16'h0000, 16'h0000, 16'h5555, 16'hAAAA, 16'h0100};
    logic [2:0]  t_cls [10] = '{3'd1, 3'd1, 3'd1, 3'd6, 3'd7, 3'd0, 3'd0, 3'd4, 3'd5, 3'd2};
    logic        t_len [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst_n = 1'b0; en = 1'b0; fch_vld = 1'b0; fch_pc = '0; fch_op = '0;
        flush = 1'b0; trc_rdy = 1'b0;
        tick(); tick();
        check("rst_vld", trc_vld, 0);
        check("rst_lvl", lvl, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1; en = 1'b1;

        // One-word instruction
        fetch(16'h0010, 16'h0C01);
        check("t1_vld", trc_vld, 1);
        check("t1_pc", trc_pc, 16'h0010);
        check("t1_op", trc_op, 32'h0000_0C01);
        check("t1_len", trc_len, 0);
        check("t1_cls", trc_cls, 0);
        check("t1_lost", trc_lost, 0);
        pop();
        check("t1_lvl_after_pop", lvl, 0);

        // Two-word call
        fetch(16'h0020, 16'h940E);
        check("t2_no_rec_word0", trc_vld, 0);
        fetch(16'h0021, 16'h1234);
        check("t2_vld", trc_vld, 1);
        check("t2_op", trc_op, 32'h1234_940E);
        check("t2_len", trc_len, 1);
        check("t2_cls", trc_cls, 3);
        check("t2_pc", trc_pc, 16'h0020);
        check("t2_lvl", lvl, 1);
        pop();

        // Flush discards a partial lds
        fetch(16'h0030, 16'h9100);
        flush = 1'b1;
        fetch(16'h0031, 16'h0000);
        flush = 1'b0;
        check("t3_no_rec", trc_vld, 0);
        fetch(16'h0040, 16'h9508);
        check("t3_vld", trc_vld, 1);
        check("t3_cls", trc_cls, 6);
        check("t3_len", trc_len, 0);
        check("t3_pc", trc_pc, 16'h0040);
        check("t3_drop", drop_cnt, 0);
        pop();

        // en=0 in SECOND drops the partial; next word starts fresh
        fetch(16'h0050, 16'h940C);
        en = 1'b0;
        fetch(16'h0051, 16'h0200);
        en = 1'b1;
        check("en0_no_rec", trc_vld, 0);
        fetch(16'h0060, 16'h0C01);
        check("en0_len", trc_len, 0);
        check("en0_op", trc_op, 32'h0000_0C01);
        pop();

        // Classification table
        for (int i = 0; i < 10; i++) begin
            fetch(16'(16'h0080 + i), t_w0[i]);
            if (t_len[i])
                fetch(16'(16'h0081 + i), t_w1[i]);
            check($sformatf("cls_%0d", i), trc_cls, t_cls[i]);
            check($sformatf("len_%0d", i), trc_len, t_len[i]);
            check($sformatf("op_%0d", i), trc_op, {t_w1[i], t_w0[i]});
            pop();
        end

        // Overflow: DEPTH+3 pushes, no pops
        for (int i = 0; i < c_DEPTH + 3; i++)
            fetch(16'(16'h0100 + i), 16'h0000);
        check("t4_lvl", lvl, c_DEPTH);
        check("t4_drop", drop_cnt, 3);
        check("t4_ovf", ovf, 1);
        check("t4_head_pc", trc_pc, 16'h0100);
        check("t4_head_lost", trc_lost, 0);
        pop();
        check("t4_lvl_pop", lvl, c_DEPTH - 1);
        fetch(16'h0200, 16'h0000);
        check("t4_lvl_refill", lvl, c_DEPTH);
        check("t4_drop_hold", drop_cnt, 3);

        // Full FIFO: simultaneous push and pop
        trc_rdy = 1'b1;
        fetch(16'h0300, 16'h0000);
        trc_rdy = 1'b0;
        check("t5_lvl", lvl, c_DEPTH);
        check("t5_drop", drop_cnt, 3);
        check("t5_head_pc", trc_pc, 16'h0102);

        for (int i = 0; i < 14; i++) begin
            check($sformatf("drain_pc_%0d", i), trc_pc, 16'(16'h0102 + i));
            pop();
        end
        check("t4_lost_pc", trc_pc, 16'h0200);
        check("t4_lost_flag", trc_lost, 1);
        pop();
        check("t5_rec_pc", trc_pc, 16'h0300);
        check("t5_rec_lost", trc_lost, 0);
        pop();
        check("drain_empty", trc_vld, 0);
        check("ovf_sticky", ovf, 1);

        // Reset mid-instruction with FIFO half full
        for (int i = 0; i < c_DEPTH / 2; i++)
            fetch(16'(16'h0400 + i), 16'h0000);
        fetch(16'h0500, 16'h940C);
        check("t6_pre_lvl", lvl, c_DEPTH / 2);
        rst_n = 1'b0;
        tick();
        check("t6_vld", trc_vld, 0);
        check("t6_lvl", lvl, 0);
        check("t6_ovf", ovf, 0);
        check("t6_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();
        fetch(16'h0600, 16'h940C);
        fetch(16'h0601, 16'h0040);
        check("t6_cls", trc_cls, 2);
        check("t6_len", trc_len, 1);
        check("t6_op", trc_op, 32'h0040_940C);
        check("t6_pc", trc_pc, 16'h0600);
        check("t6_lost", trc_lost, 0);
`ifdef RP_8BIT_TRACE_TS_EN
        check("t6_ts", trc_ts, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
